// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush/bubble insertion and
// saturating stall/starve counters. Define PIPE_STAGE_SKID_EN for a registered in_ready.
module pipe_stage_reg #(
  parameter int              DW       = 32,
  parameter int              CW       = 9,
  parameter logic [CW-1:0]   CTRL_NOP = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic [CW-1:0]    in_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [CW-1:0]    out_ctrl,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] starve_cnt
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] ctrl_q, ctrl_d;
  logic          in_xfer;

  assign in_xfer   = in_valid & in_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  // Bubbles always present the NOP control, whatever the held ctrl register says.
  assign out_ctrl  = valid_q ? ctrl_q : CTRL_NOP;

`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic {EMPTY, FULL} skid_t;

  skid_t         state_q, state_d;
  logic [DW-1:0] skid_data_q, skid_data_d;
  logic [CW-1:0] skid_ctrl_q, skid_ctrl_d;

  assign in_ready = (state_q == EMPTY) & ~flush & ~reset;

  always_comb begin
    valid_d     = valid_q;
    data_d      = data_q;
    ctrl_d      = ctrl_q;
    state_d     = state_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
      state_d = EMPTY;
    end else if (state_q == FULL) begin
      if (out_ready) begin
        valid_d = 1'b1;
        data_d  = skid_data_q;
        ctrl_d  = skid_ctrl_q;
        state_d = EMPTY;
      end
    end else if (in_xfer) begin
      // Accepted while stalled: park the bundle in the skid slot.
      if (valid_q && !out_ready) begin
        skid_data_d = in_data;
        skid_ctrl_d = in_ctrl;
        state_d     = FULL;
      end else begin
        valid_d = 1'b1;
        data_d  = in_data;
        ctrl_d  = in_ctrl;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      skid_data_q <= '0;
      skid_ctrl_q <= CTRL_NOP;
    end else begin
      state_q     <= state_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end
`else
  assign in_ready = (~valid_q | out_ready) & ~flush & ~reset;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_xfer) begin
      valid_d = 1'b1;
      data_d  = in_data;
      ctrl_d  = in_ctrl;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= CTRL_NOP;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Saturating performance counters; clear wins over increment, flush is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      starve_cnt <= '0;
    end else begin
      if (cnt_clr)
        stall_cnt <= '0;
      else if (valid_q && !out_ready && !(&stall_cnt))
        stall_cnt <= stall_cnt + 1'b1;
      if (cnt_clr)
        starve_cnt <= '0;
      else if (!valid_q && out_ready && !(&starve_cnt))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule
